// File: rtl/serial_cmd_decoder.sv
// Sync-word command decoder with multi-word parameter frames. Outputs update one cycle after the strobe.
// No backpressure: every strobe is consumed. `SERIAL_CMD_CHECKSUM_EN adds a trailing checksum word.
module serial_cmd_decoder #(
  parameter int DATA_WIDTH     = 16,
  parameter int PAYLOAD_WORDS  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ZERO_PULSE_LEN = 1,
  parameter logic [DATA_WIDTH-1:0] SYNC_ENCODE     = 'hECDE,
  parameter logic [DATA_WIDTH-1:0] SYNC_SCAN_BEGIN = 'h5A51,
  parameter logic [DATA_WIDTH-1:0] SYNC_SCAN_TEST  = 'h5A53,
  parameter logic [DATA_WIDTH-1:0] SYNC_SCAN_END   = 'h5A50,
  parameter logic [DATA_WIDTH-1:0] SYNC_PARAM      = 'h5A5C
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                rx_valid_i,
  input  logic [DATA_WIDTH-1:0]               rx_data_i,
  output logic                                encode_zero_flag_o,
  output logic                                scan_start_flag_o,
  output logic                                scan_test_flag_o,
  output logic                                param_valid_o,
  output logic [PAYLOAD_WORDS*DATA_WIDTH-1:0] param_data_o,
  output logic [7:0]                          frame_err_cnt_o
);

  localparam int IDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int ZP_W  = $clog2(ZERO_PULSE_LEN + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ZP_W-1:0]  ZP_RELOAD = ZP_W'(ZERO_PULSE_LEN - 1);

`ifdef SERIAL_CMD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
  logic [DATA_WIDTH-1:0] csum;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD} state_t;
`endif

  state_t                                  state;
  logic [IDX_W-1:0]                        idx;
  logic [TMO_W-1:0]                        tmo_cnt;
  logic [ZP_W-1:0]                         zp_cnt;
  logic [PAYLOAD_WORDS-1:0][DATA_WIDTH-1:0] shadow;
  logic [PAYLOAD_WORDS-1:0][DATA_WIDTH-1:0] shadow_nxt;
  logic                                    cmd_encode;

  // Shadow with the incoming word merged in, so the last word commits in the same edge.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[idx] = rx_data_i;
  end

  assign cmd_encode = (state == IDLE) && rx_valid_i && (rx_data_i == SYNC_ENCODE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      idx                <= '0;
      tmo_cnt            <= '0;
      zp_cnt             <= '0;
      shadow             <= '0;
      encode_zero_flag_o <= 1'b0;
      scan_start_flag_o  <= 1'b0;
      scan_test_flag_o   <= 1'b0;
      param_valid_o      <= 1'b0;
      param_data_o       <= '0;
      frame_err_cnt_o    <= '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
      csum               <= '0;
`endif
    end else begin
      param_valid_o <= 1'b0;

      // A repeated encode command reloads the count, stretching the pulse.
      if (cmd_encode) begin
        encode_zero_flag_o <= 1'b1;
        zp_cnt             <= ZP_RELOAD;
      end else if (zp_cnt != '0) begin
        zp_cnt <= zp_cnt - 1'b1;
      end else begin
        encode_zero_flag_o <= 1'b0;
      end

      // Inter-word timeout; a strobe on the final cycle wins over the abort.
      if ((state != IDLE) && !rx_valid_i) begin
        if (tmo_cnt == TMO_LAST) begin
          state <= IDLE;
          if (frame_err_cnt_o != 8'hFF) frame_err_cnt_o <= frame_err_cnt_o + 8'd1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      if (rx_valid_i) begin
        case (state)
          IDLE: begin
            if (rx_data_i == SYNC_SCAN_BEGIN) begin
              scan_start_flag_o <= 1'b1;
              scan_test_flag_o  <= 1'b0;
            end else if (rx_data_i == SYNC_SCAN_TEST) begin
              scan_start_flag_o <= 1'b1;
              scan_test_flag_o  <= 1'b1;
            end else if (rx_data_i == SYNC_SCAN_END) begin
              scan_start_flag_o <= 1'b0;
            end else if (rx_data_i == SYNC_PARAM) begin
              state   <= PAYLOAD;
              idx     <= '0;
              tmo_cnt <= '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
              csum    <= '0;
`endif
            end
          end
          PAYLOAD: begin
            tmo_cnt <= '0;
            shadow  <= shadow_nxt;
            idx     <= idx + 1'b1;
`ifdef SERIAL_CMD_CHECKSUM_EN
            csum    <= csum + rx_data_i;
            if (idx == LAST_IDX) state <= CHECK;
`else
            if (idx == LAST_IDX) begin
              param_data_o  <= shadow_nxt;
              param_valid_o <= 1'b1;
              state         <= IDLE;
            end
`endif
          end
`ifdef SERIAL_CMD_CHECKSUM_EN
          CHECK: begin
            tmo_cnt <= '0;
            state   <= IDLE;
            if (rx_data_i == csum) begin
              param_data_o  <= shadow;
              param_valid_o <= 1'b1;
            end else if (frame_err_cnt_o != 8'hFF) begin
              frame_err_cnt_o <= frame_err_cnt_o + 8'd1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
